// File: rtl/mem_req_ctrl_if.sv
// rtl/mem_req_ctrl_if.sv - cache request and memory array signal bundle for mem_req_ctrl
interface mem_req_ctrl_if;
    logic         ic_req;
    logic [14:0]  ic_addr;
    logic         ic_ack;
    logic [127:0] ic_rdata;
    logic         dc_req;
    logic         dc_wr;
    logic [14:0]  dc_addr;
    logic [15:0]  dc_be;
    logic [127:0] dc_wdata;
    logic         dc_ack;
    logic [127:0] dc_rdata;
    logic [14:0]  mem_addr;
    logic         mem_ce_n;
    logic         mem_oe_n;
    logic [15:0]  mem_we_n;
    logic [127:0] mem_wdata;
    logic         mem_wdata_en;
    logic [127:0] mem_rdata;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_be, dc_wdata, mem_rdata,
        output ic_ack, ic_rdata, dc_ack, dc_rdata,
        output mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata, mem_wdata_en
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_be, dc_wdata, mem_rdata,
        input  ic_ack, ic_rdata, dc_ack, dc_rdata,
        input  mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_wdata, mem_wdata_en
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - arbitrates icache/dcache line requests onto a fixed-window 128-bit memory array
module mem_req_ctrl #(
    parameter int unsigned LAT = 4
) (
    input  logic         clk_i,
    input  logic         clr_n_i,
    mem_req_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e       state_q;
    logic         last_dc_q;
    logic         sel_dc_q;
    logic         wr_q;
    logic [3:0]   cnt_q;
    logic [14:0]  mem_addr_q;
    logic         mem_ce_n_q;
    logic         mem_oe_n_q;
    logic [15:0]  mem_we_n_q;
    logic [127:0] mem_wdata_q;
    logic         mem_wdata_en_q;
    logic         ic_ack_q;
    logic         dc_ack_q;
    logic [127:0] ic_rdata_q;
    logic [127:0] dc_rdata_q;

    logic         req_any_d;
    logic         gnt_dc_d;
    logic         wr_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        req_any_d = bus.ic_req | bus.dc_req;
        gnt_dc_d  = bus.dc_req & (~bus.ic_req | ~last_dc_q);
        wr_d      = gnt_dc_d & bus.dc_wr;
    end

    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q        <= IDLE;
            last_dc_q      <= 1'b1;
            sel_dc_q       <= 1'b0;
            wr_q           <= 1'b0;
            cnt_q          <= 4'd0;
            mem_addr_q     <= 15'd0;
            mem_ce_n_q     <= 1'b1;
            mem_oe_n_q     <= 1'b1;
            mem_we_n_q     <= 16'hFFFF;
            mem_wdata_q    <= 128'd0;
            mem_wdata_en_q <= 1'b0;
            ic_ack_q       <= 1'b0;
            dc_ack_q       <= 1'b0;
            ic_rdata_q     <= 128'd0;
            dc_rdata_q     <= 128'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any_d) begin
                        state_q        <= ACCESS;
                        sel_dc_q       <= gnt_dc_d;
                        last_dc_q      <= gnt_dc_d;
                        wr_q           <= wr_d;
                        cnt_q          <= 4'(LAT - 1);
                        mem_addr_q     <= gnt_dc_d ? bus.dc_addr : bus.ic_addr;
                        mem_ce_n_q     <= 1'b0;
                        mem_oe_n_q     <= wr_d;
                        mem_we_n_q     <= wr_d ? ~bus.dc_be : 16'hFFFF;
                        mem_wdata_en_q <= wr_d;
                        if (wr_d) begin
                            mem_wdata_q <= bus.dc_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= RESP;
                        mem_ce_n_q <= 1'b1;
                        mem_oe_n_q <= 1'b1;
                        mem_we_n_q <= 16'hFFFF;
                        ic_ack_q   <= ~sel_dc_q;
                        dc_ack_q   <= sel_dc_q;
                        if (!wr_q) begin
                            if (sel_dc_q) dc_rdata_q <= bus.mem_rdata;
                            else          ic_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    // Write data was held through this cycle for the array's hold time.
                    state_q        <= IDLE;
                    mem_wdata_en_q <= 1'b0;
                    ic_ack_q       <= 1'b0;
                    dc_ack_q       <= 1'b0;
                    ic_rdata_q     <= 128'd0;
                    dc_rdata_q     <= 128'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_ce_n     = mem_ce_n_q;
    assign bus.mem_oe_n     = mem_oe_n_q;
    assign bus.mem_we_n     = mem_we_n_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wdata_en = mem_wdata_en_q;
    assign bus.ic_ack       = ic_ack_q;
    assign bus.dc_ack       = dc_ack_q;
    assign bus.ic_rdata     = ic_rdata_q;
    assign bus.dc_rdata     = dc_rdata_q;

endmodule
